// File: rtl/fibonacci_multi_lane_pkg.sv
// fib_pkg: shared FSM state type, lane limit and term-width helper
// for the multi-lane Fibonacci generator.
package fib_pkg;

  typedef enum logic [1:0] {
    FIB_IDLE,
    FIB_RUN,
    FIB_DONE
  } fib_state_t;

  localparam int FIB_MAX_LANES = 4;

  // Internal term width: one guard bit above W.
  function automatic int fib_tw(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/fibonacci_multi_lane_if.sv
// Handshake/bus bundle of fibonacci_multi_lane: load + seeds in,
// valid/ready beat of LANES terms, lane_mask, done, ovf out.
interface fibonacci_multi_lane_if #(
  parameter int W     = 16,
  parameter int LANES = 2
);
  logic               load;
  logic [W-1:0]       seed0;
  logic [W-1:0]       seed1;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] num;
  logic [LANES-1:0]   lane_mask;
  logic               done;
  logic               ovf;

  modport master (
    output load, seed0, seed1, out_ready,
    input  out_valid, num, lane_mask, done, ovf
  );

  modport slave (
    input  load, seed0, seed1, out_ready,
    output out_valid, num, lane_mask, done, ovf
  );
endinterface

// File: rtl/fibonacci_multi_lane_advance.sv
// fib_advance: combinational chain t0=a, t1=b, t(i)=t(i-2)+t(i-1)
// for i up to LANES+1, with per-term overflow flags. FIB_WRAP_EN wraps.
module fib_advance
  import fib_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic [fib_tw(W)-1:0]                a_i,
  input  logic [fib_tw(W)-1:0]                b_i,
  input  logic                                a_ov_i,
  input  logic                                b_ov_i,
  output logic [LANES+1:0][fib_tw(W)-1:0]     t_o,
  output logic [LANES+1:0]                    ov_o
);

  always_comb begin
    logic [W:0] s;
    s     = '0;
    t_o   = '0;
    ov_o  = '0;
    t_o[0]  = a_i;
    t_o[1]  = b_i;
    ov_o[0] = a_ov_i;
    ov_o[1] = b_ov_i;
    for (int i = 2; i < LANES + 2; i++) begin
      // Overflowed operands make the value don't-care,
      // so the W-bit sum is exact whenever it matters.
      s = {1'b0, t_o[i-2][W-1:0]}
        + {1'b0, t_o[i-1][W-1:0]};
`ifdef FIB_WRAP_EN
      t_o[i] = {1'b0, s[W-1:0]};
`else
      t_o[i] = s;
`endif
      ov_o[i] = s[W] | ov_o[i-2] | ov_o[i-1];
    end
  end

endmodule

// File: rtl/fibonacci_multi_lane.sv
// fibonacci_multi_lane: LANES Fibonacci-type terms per valid/ready beat,
// any seed pair, per-lane overflow mask. Ports: clk, rst_n, bus (slave).
// Option: FIB_WRAP_EN makes arithmetic modulo 2^W and never halts.
module fibonacci_multi_lane
  import fib_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fibonacci_multi_lane_if.slave bus
);

  localparam int TW = fib_tw(W);

  if (LANES < 1 || LANES > FIB_MAX_LANES) begin : g_bad_lanes
    $error("LANES out of range");
  end

  fib_state_t state_q, state_d;
  logic [TW-1:0] a_q, a_d, b_q, b_d;
  logic a_ov_q, a_ov_d, b_ov_q, b_ov_d;
  logic ovf_q, ovf_d;

  logic [LANES+1:0][TW-1:0] t;
  logic [LANES+1:0]         tov;
  logic [LANES-1:0]         mask;
  logic run, xfer, beat_ov;

  fib_advance #(.W(W), .LANES(LANES)) u_adv (
    .a_i    (a_q),
    .b_i    (b_q),
    .a_ov_i (a_ov_q),
    .b_ov_i (b_ov_q),
    .t_o    (t),
    .ov_o   (tov)
  );

  assign run     = (state_q == FIB_RUN);
  assign xfer    = run & bus.out_ready;
  assign beat_ov = run & (|tov[LANES-1:0]);

  always_comb begin
    mask    = '0;
    bus.num = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef FIB_WRAP_EN
      mask[i] = run;
`else
      mask[i] = run & ~tov[i];
`endif
      if (mask[i]) bus.num[i*W +: W] = t[i][W-1:0];
    end
  end

  assign bus.lane_mask = mask;
  assign bus.out_valid = run;
  // Flag shows as soon as an overflowing term is on the lanes.
  assign bus.ovf       = ovf_q | beat_ov;
`ifdef FIB_WRAP_EN
  assign bus.done      = 1'b0;
`else
  assign bus.done      = (state_q == FIB_DONE);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ov_d  = a_ov_q;
    b_ov_d  = b_ov_q;
    ovf_d   = ovf_q | beat_ov;
    if (bus.load) begin
      state_d = FIB_RUN;
      a_d     = {1'b0, bus.seed0};
      b_d     = {1'b0, bus.seed1};
      a_ov_d  = 1'b0;
      b_ov_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (xfer) begin
      a_d    = t[LANES];
      b_d    = t[LANES+1];
      a_ov_d = tov[LANES];
      b_ov_d = tov[LANES+1];
`ifndef FIB_WRAP_EN
      if (!(&mask)) state_d = FIB_DONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIB_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_ov_q  <= 1'b0;
      b_ov_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ov_q  <= a_ov_d;
      b_ov_q  <= b_ov_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fibonacci_multi_lane.sv
// Bench: four configurations side by side, a per-instance sequence
// model checked every cycle, plus hand-computed beats.
module tb_fibonacci_multi_lane;

  localparam int NI = 4;

  function automatic int wof(input int g);
    if (g == 2) return 8;
    return 16;
  endfunction

  function automatic int lof(input int g);
    if (g == 0) return 2;
    if (g == 3) return 1;
    return 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load [NI];
  logic [31:0] s0   [NI];
  logic [31:0] s1   [NI];
  logic        rdy  [NI];

  logic [127:0] numv  [NI];
  logic [3:0]   maskv [NI];
  logic         valv  [NI];
  logic         donev [NI];
  logic         ovfv  [NI];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input longint unsigned got,
                     input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic longint unsigned fibt(input longint unsigned a,
                                           input longint unsigned b,
                                           input int n);
    longint unsigned x, y, z;
    x = a;
    y = b;
    for (int i = 0; i < n; i++) begin
      z = x + y;
      x = y;
      y = z;
    end
    return x;
  endfunction

  function automatic longint unsigned lane(input int g, input int i);
    longint unsigned m;
    m = (64'd1 << wof(g)) - 64'd1;
    return 64'(numv[g] >> (i * wof(g))) & m;
  endfunction

  task automatic beat(input string nm, input int g,
                      input longint unsigned e0,
                      input longint unsigned e1,
                      input longint unsigned e2);
    longint unsigned e [3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    for (int i = 0; i < lof(g); i++)
      chk($sformatf("%s_lane%0d", nm, i), lane(g, i), e[i]);
  endtask

  for (genvar g = 0; g < NI; g++) begin : G
    localparam int GW = wof(g);
    localparam int GL = lof(g);

    fibonacci_multi_lane_if #(.W(GW), .LANES(GL)) ifc ();

    fibonacci_multi_lane #(.W(GW), .LANES(GL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );

    assign ifc.load      = load[g];
    assign ifc.seed0     = s0[g][GW-1:0];
    assign ifc.seed1     = s1[g][GW-1:0];
    assign ifc.out_ready = rdy[g];
    assign numv[g]       = 128'(ifc.num);
    assign maskv[g]      = 4'(ifc.lane_mask);
    assign valv[g]       = ifc.out_valid;
    assign donev[g]      = ifc.done;
    assign ovfv[g]       = ifc.ovf;

    longint unsigned ms0, ms1;
    int mk;
    bit mrun, mdone, mst;

    always @(negedge clk) begin
      bit anyov, ov, m;
      longint unsigned tv, ev;
      anyov = 1'b0;
      if (!rst_n) begin
        mrun  = 1'b0;
        mdone = 1'b0;
        mst   = 1'b0;
        mk    = 0;
      end else begin
        chk($sformatf("m%0d_valid", g), valv[g], mrun);
        chk($sformatf("m%0d_done", g), donev[g], mdone);
        if (mrun) begin
          for (int i = 0; i < GL; i++) begin
            tv = fibt(ms0, ms1, mk + i);
            ov = (tv >= (64'd1 << GW));
            anyov |= ov;
`ifdef FIB_WRAP_EN
            ev = tv & ((64'd1 << GW) - 64'd1);
            m  = 1'b1;
`else
            ev = ov ? 64'd0 : tv;
            m  = !ov;
`endif
            chk($sformatf("m%0d_T%0d", g, mk + i), lane(g, i), ev);
            chk($sformatf("m%0d_mask%0d", g, i), maskv[g][i], m);
          end
        end
        chk($sformatf("m%0d_ovf", g), ovfv[g], mst | anyov);
        mst = mst | anyov;
        if (load[g]) begin
          ms0   = 64'(s0[g]);
          ms1   = 64'(s1[g]);
          mk    = 0;
          mrun  = 1'b1;
          mdone = 1'b0;
          mst   = 1'b0;
        end else if (mrun && rdy[g]) begin
          mk += GL;
`ifndef FIB_WRAP_EN
          if (anyov) begin
            mrun  = 1'b0;
            mdone = 1'b1;
          end
`endif
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      load[g] = 1'b0;
      s0[g]   = '0;
      s1[g]   = '0;
      rdy[g]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst%0d_valid", g), valv[g], 0);
      chk($sformatf("rst%0d_num", g), 64'(numv[g]), 0);
      chk($sformatf("rst%0d_mask", g), maskv[g], 0);
      chk($sformatf("rst%0d_done", g), donev[g], 0);
      chk($sformatf("rst%0d_ovf", g), ovfv[g], 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s0[0] = 0; s1[0] = 1;
    s0[1] = 2; s1[1] = 1;
    s0[2] = 0; s1[2] = 1;
    s0[3] = 0; s1[3] = 1;
    for (int g = 0; g < NI; g++) begin
      load[g] = 1'b1;
      rdy[g]  = 1'b1;
    end

    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) load[g] = 1'b0;
      if (c == 2) rdy[0] = 1'b0;
      if (c == 5) rdy[0] = 1'b1;
      if (c == 7) begin
        load[2] = 1'b1; s0[2] = 5; s1[2] = 8;
      end
      if (c == 8) begin
        load[0] = 1'b1; s0[0] = 5; s1[0] = 8;
      end
      if (c == 12) rdy[1] = 1'b0;
      @(negedge clk);
      case (c)
        0: begin
          beat("fib_b0", 0, 0, 1, 0);
          chk("fib_b0_mask", maskv[0], 3);
          beat("luc_b0", 1, 2, 1, 3);
          beat("w8_b0", 2, 0, 1, 1);
        end
        1: begin
          beat("fib_b1", 0, 1, 2, 0);
          beat("luc_b1", 1, 4, 7, 11);
        end
        2: beat("luc_b2", 1, 18, 29, 47);
        3: beat("stall_a", 0, 3, 5, 0);
        4: begin
`ifdef FIB_WRAP_EN
          beat("w8_b4", 2, 144, 233, 121);
          chk("w8_b4_mask", maskv[2], 7);
`else
          beat("w8_b4", 2, 144, 233, 0);
          chk("w8_b4_mask", maskv[2], 3);
`endif
          chk("w8_b4_ovf", ovfv[2], 1);
        end
        5: begin
          beat("stall_b", 0, 3, 5, 0);
`ifdef FIB_WRAP_EN
          chk("w8_run_valid", valv[2], 1);
`else
          chk("w8_done", donev[2], 1);
          chk("w8_done_valid", valv[2], 0);
`endif
        end
        6: beat("after_stall", 0, 8, 13, 0);
        8: begin
          beat("w8_restart", 2, 5, 8, 13);
          chk("w8_restart_ovf", ovfv[2], 0);
          chk("w8_restart_done", donev[2], 0);
        end
        9: begin
          beat("reload", 0, 5, 8, 0);
          chk("reload_ovf", ovfv[0], 0);
        end
        24: begin
          chk("l1_F24", lane(3, 0), 46368);
          chk("l1_F24_mask", maskv[3], 1);
        end
        25: begin
`ifndef FIB_WRAP_EN
          chk("l1_F25", lane(3, 0), 0);
          chk("l1_F25_mask", maskv[3], 0);
`endif
        end
        26: begin
`ifndef FIB_WRAP_EN
          chk("l1_done", donev[3], 1);
`endif
        end
        default: ;
      endcase
    end

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("arst%0d_valid", g), valv[g], 0);
      chk($sformatf("arst%0d_num", g), 64'(numv[g]), 0);
      chk($sformatf("arst%0d_mask", g), maskv[g], 0);
      chk($sformatf("arst%0d_done", g), donev[g], 0);
      chk($sformatf("arst%0d_ovf", g), ovfv[g], 0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int g = 0; g < NI; g++)
      chk($sformatf("idle%0d_valid", g), valv[g], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
